// File: rtl/i2c_slave.sv
// I2C target with a 7-bit address, byte-wide write delivery and read handshake.
// Define I2C_SLAVE_GLITCH_FILTER_EN to insert a FILT_LEN-sample filter behind the synchronizers.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         FILT_LEN   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  logic       sda,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       ack_err
);

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  localparam bit FilterOn = 1'b1;
`else
  localparam bit FilterOn = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  logic scl_s1, scl_s2, sda_s1, sda_s2;
  logic scl_f, sda_f;
  logic scl_p, sda_p;
  logic scl_rise, scl_fall, start_det, stop_det;

  state_t     state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift, shift_n, shift_in;
  logic [7:0] rx_data_n;
  logic       phase, phase_n;
  logic       rw, rw_n;
  logic       sda_oe, sda_oe_n;
  logic       rx_valid_n, tx_req_n, ack_err_n;

  // Pins are idle-high, so the synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
    end else begin
      scl_s1 <= scl;
      scl_s2 <= scl_s1;
      sda_s1 <= sda;
      sda_s2 <= sda_s1;
    end
  end

  if (FilterOn && FILT_LEN > 1) begin : g_filter
    localparam int CntW = $clog2(FILT_LEN);
    logic [CntW-1:0] scl_cnt, sda_cnt;
    logic            scl_q, sda_q;

    // A line only follows its synchronized input after FILT_LEN differing samples in a row.
    always_ff @(posedge clk) begin
      if (rst) begin
        scl_q   <= 1'b1;
        sda_q   <= 1'b1;
        scl_cnt <= '0;
        sda_cnt <= '0;
      end else begin
        if (scl_s2 == scl_q) begin
          scl_cnt <= '0;
        end else if (scl_cnt == CntW'(FILT_LEN - 1)) begin
          scl_q   <= scl_s2;
          scl_cnt <= '0;
        end else begin
          scl_cnt <= scl_cnt + 1'b1;
        end
        if (sda_s2 == sda_q) begin
          sda_cnt <= '0;
        end else if (sda_cnt == CntW'(FILT_LEN - 1)) begin
          sda_q   <= sda_s2;
          sda_cnt <= '0;
        end else begin
          sda_cnt <= sda_cnt + 1'b1;
        end
      end
    end

    assign scl_f = scl_q;
    assign sda_f = sda_q;
  end else begin : g_bypass
    assign scl_f = scl_s2;
    assign sda_f = sda_s2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_p <= 1'b1;
      sda_p <= 1'b1;
    end else begin
      scl_p <= scl_f;
      sda_p <= sda_f;
    end
  end

  assign scl_rise  =  scl_f & ~scl_p;
  assign scl_fall  = ~scl_f &  scl_p;
  assign start_det =  scl_f &  sda_p & ~sda_f;
  assign stop_det  =  scl_f & ~sda_p &  sda_f;
  assign shift_in  = {shift[6:0], sda_f};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      shift    <= 8'h00;
      phase    <= 1'b0;
      rw       <= 1'b0;
      sda_oe   <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      ack_err  <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
      phase    <= phase_n;
      rw       <= rw_n;
      sda_oe   <= sda_oe_n;
      rx_data  <= rx_data_n;
      rx_valid <= rx_valid_n;
      tx_req   <= tx_req_n;
      ack_err  <= ack_err_n;
    end
  end

  // phase marks the second half of an ACK slot, or a read byte whose first bit is still pending.
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    phase_n    = phase;
    rw_n       = rw;
    sda_oe_n   = sda_oe;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    tx_req_n   = 1'b0;
    ack_err_n  = ack_err;

    if (start_det) begin
      state_n   = ADDR;
      bit_cnt_n = 3'd0;
      phase_n   = 1'b0;
      sda_oe_n  = 1'b0;
      ack_err_n = 1'b0;
    end else if (stop_det) begin
      state_n   = IDLE;
      bit_cnt_n = 3'd0;
      phase_n   = 1'b0;
      sda_oe_n  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sda_oe_n = 1'b0;
        end
        ADDR: begin
          if (scl_rise) begin
            shift_n = shift_in;
            if (bit_cnt == 3'd7) begin
              bit_cnt_n = 3'd0;
              phase_n   = 1'b0;
              if (shift_in[7:1] == SLAVE_ADDR) begin
                rw_n    = shift_in[0];
                state_n = ADDR_ACK;
              end else begin
                state_n = WAIT_STOP;
              end
            end else begin
              bit_cnt_n = bit_cnt + 3'd1;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!phase) begin
              phase_n  = 1'b1;
              sda_oe_n = 1'b1;
              if (rw) begin
                tx_req_n = 1'b1;
                shift_n  = tx_data;
              end
            end else begin
              phase_n = 1'b0;
              if (rw) begin
                sda_oe_n = ~shift[7];
                state_n  = RD_DATA;
              end else begin
                sda_oe_n = 1'b0;
                state_n  = WR_DATA;
              end
            end
          end
        end
        WR_DATA: begin
          if (scl_rise) begin
            shift_n = shift_in;
            if (bit_cnt == 3'd7) begin
              bit_cnt_n  = 3'd0;
              rx_data_n  = shift_in;
              rx_valid_n = 1'b1;
              phase_n    = 1'b0;
              state_n    = WR_ACK;
            end else begin
              bit_cnt_n = bit_cnt + 3'd1;
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            if (!phase) begin
              phase_n  = 1'b1;
              sda_oe_n = 1'b1;
            end else begin
              phase_n  = 1'b0;
              sda_oe_n = 1'b0;
              state_n  = WR_DATA;
            end
          end
        end
        RD_DATA: begin
          if (scl_fall) begin
            if (phase) begin
              phase_n  = 1'b0;
              sda_oe_n = ~shift[7];
            end else if (bit_cnt == 3'd7) begin
              bit_cnt_n = 3'd0;
              sda_oe_n  = 1'b0;
              state_n   = RD_ACK;
            end else begin
              shift_n   = {shift[6:0], 1'b0};
              sda_oe_n  = ~shift[6];
              bit_cnt_n = bit_cnt + 3'd1;
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (!sda_f) begin
              tx_req_n = 1'b1;
              shift_n  = tx_data;
              phase_n  = 1'b1;
              state_n  = RD_DATA;
            end else begin
              ack_err_n = 1'b1;
              state_n   = WAIT_STOP;
            end
          end
        end
        WAIT_STOP: begin
          sda_oe_n = 1'b0;
        end
        default: begin
          state_n  = IDLE;
          sda_oe_n = 1'b0;
        end
      endcase
    end
  end

  assign busy = (state == ADDR_ACK) || (state == WR_DATA) || (state == WR_ACK) ||
                (state == RD_DATA)  || (state == RD_ACK);

  // Open-drain: only ever pull low, otherwise let the bus pull-up win.
  assign sda = sda_oe ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-banged bus master plus scoreboard queues for rx_valid and tx_req.
// Expected behaviour comes from a transaction-level model of the addressing and data rules.
module tb_i2c_slave;
  localparam logic [6:0] SLAVE_ADDR = 7'h50;
  localparam int Q = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       m_sda_low;
  logic [7:0] tx_data;
  logic       tx_req;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       ack_err;
  wire        sda;

  pullup (sda);
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  i2c_slave #(.SLAVE_ADDR(SLAVE_ADDR), .FILT_LEN(3)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda), .tx_data(tx_data), .tx_req(tx_req),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];
  logic [7:0] plan[$];
  bit         ack_err_exp;
  bit         acked;
  bit         rbit;
  logic [7:0] got;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    tests++;
    if (actual !== required) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
    end
  endtask

  // Monitor: every DUT-presented event consumes one scoreboard entry.
  always @(negedge clk) begin
    if (!rst && rx_valid) begin
      checkOutput("rx_valid_expected", exp_rx.size() > 0, 1);
      if (exp_rx.size() > 0) checkOutput("rx_data", rx_data, exp_rx.pop_front());
    end
    if (!rst && tx_req) begin
      checkOutput("tx_req_expected", exp_tx.size() > 0, 1);
      if (exp_tx.size() > 0) checkOutput("tx_data_at_req", tx_data, exp_tx.pop_front());
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda_low = 1'b0; wait_clk(Q);
    scl = 1'b1;       wait_clk(Q);
    m_sda_low = 1'b1; wait_clk(Q);
    scl = 1'b0;       wait_clk(Q);
    ack_err_exp = 1'b0;
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1; wait_clk(Q);
    scl = 1'b1;       wait_clk(Q);
    m_sda_low = 1'b0; wait_clk(2 * Q);
  endtask

  task automatic send_bit(input bit b);
    m_sda_low = !b; wait_clk(Q);
    scl = 1'b1;     wait_clk(2 * Q);
    scl = 1'b0;     wait_clk(Q);
  endtask

  task automatic recv_bit(output bit b);
    m_sda_low = 1'b0; wait_clk(Q);
    scl = 1'b1;       wait_clk(Q);
    b = (sda === 1'b1);
    wait_clk(Q);
    scl = 1'b0;       wait_clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ack);
    bit r;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(r);
    ack = !r;
  endtask

  task automatic recv_byte(output logic [7:0] b);
    bit r;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(r);
      b[i] = r;
    end
  endtask

  // One complete transaction using the bytes in plan; the master NACKs the last read byte.
  task automatic applyStimulus(input logic [6:0] addr, input bit rnw);
    bit         hit;
    bit         ack;
    logic [7:0] rd;
    hit = (addr == SLAVE_ADDR);
    if (rnw && hit) begin
      tx_data = plan[0];
      exp_tx.push_back(plan[0]);
    end
    bus_start();
    send_byte({addr, rnw}, ack);
    checkOutput("addr_ack", ack, hit);
    checkOutput("busy_after_addr", busy, hit);
    if (!rnw) begin
      for (int k = 0; k < plan.size(); k++) begin
        if (hit) exp_rx.push_back(plan[k]);
        send_byte(plan[k], ack);
        checkOutput("data_ack", ack, hit);
      end
    end else if (hit) begin
      for (int k = 0; k < plan.size(); k++) begin
        recv_byte(rd);
        checkOutput("read_byte", rd, plan[k]);
        if (k < plan.size() - 1) begin
          tx_data = plan[k + 1];
          exp_tx.push_back(plan[k + 1]);
          send_bit(1'b0);
        end else begin
          send_bit(1'b1);
          ack_err_exp = 1'b1;
        end
      end
    end
    bus_stop();
    checkOutput("busy_after_stop", busy, 0);
    checkOutput("ack_err", ack_err, ack_err_exp);
  endtask

  initial begin
    rst = 1'b1; scl = 1'b1; m_sda_low = 1'b0; tx_data = 8'h00; ack_err_exp = 1'b0;
    wait_clk(5);
    checkOutput("reset_rx_data", rx_data, 8'h00);
    checkOutput("reset_rx_valid", rx_valid, 0);
    checkOutput("reset_tx_req", tx_req, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_ack_err", ack_err, 0);
    checkOutput("reset_sda", sda, 1);
    rst = 1'b0;
    wait_clk(5);

    plan = '{8'hA5, 8'h5A};
    applyStimulus(SLAVE_ADDR, 1'b0);
    plan = '{8'h33};
    applyStimulus(7'h51, 1'b0);
    plan = '{8'h3C};
    applyStimulus(SLAVE_ADDR, 1'b1);

    // Partial write byte abandoned by a repeated START into a read.
    bus_start();
    send_byte({SLAVE_ADDR, 1'b0}, acked);
    checkOutput("rs_addr_w_ack", acked, 1);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom));
    tx_data = 8'hC3;
    exp_tx.push_back(8'hC3);
    bus_start();
    send_byte({SLAVE_ADDR, 1'b1}, acked);
    checkOutput("rs_addr_r_ack", acked, 1);
    recv_byte(got);
    checkOutput("rs_read_byte", got, 8'hC3);
    send_bit(1'b1);
    ack_err_exp = 1'b1;
    bus_stop();
    checkOutput("rs_ack_err", ack_err, ack_err_exp);

    for (int t = 0; t < 10; t++) begin
      logic [6:0] a;
      int         n;
      a = ($urandom_range(0, 2) == 0) ? 7'($urandom) : SLAVE_ADDR;
      n = $urandom_range(1, 3);
      plan.delete();
      for (int k = 0; k < n; k++) plan.push_back(8'($urandom));
      applyStimulus(a, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a read byte while the slave is pulling sda low.
    tx_data = 8'h00;
    exp_tx.push_back(8'h00);
    bus_start();
    send_byte({SLAVE_ADDR, 1'b1}, acked);
    checkOutput("rst_addr_ack", acked, 1);
    for (int i = 0; i < 4; i++) recv_bit(rbit);
    checkOutput("sda_low_before_rst", sda, 0);
    rst = 1'b1;
    wait_clk(1);
    checkOutput("sda_released_on_rst", sda, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ack_err", ack_err, 0);
    checkOutput("rst_rx_data", rx_data, 8'h00);
    checkOutput("rst_tx_req", tx_req, 0);
    checkOutput("rst_rx_valid", rx_valid, 0);
    wait_clk(2);
    rst = 1'b0;
    ack_err_exp = 1'b0;
    wait_clk(2);
    bus_stop();
    plan = '{8'($urandom), 8'($urandom)};
    applyStimulus(SLAVE_ADDR, 1'b0);

    // Short sda glitch on an idle bus; a detected START would clear ack_err.
    plan = '{8'($urandom), 8'($urandom)};
    applyStimulus(SLAVE_ADDR, 1'b1);
    wait_clk(Q);
    m_sda_low = 1'b1;
    wait_clk(2);
    m_sda_low = 1'b0;
    wait_clk(4 * Q);
`ifndef I2C_SLAVE_GLITCH_FILTER_EN
    ack_err_exp = 1'b0;
`endif
    checkOutput("glitch_ack_err", ack_err, ack_err_exp);
    checkOutput("glitch_busy", busy, 0);

    wait_clk(10);
    checkOutput("rx_left_over", exp_rx.size(), 0);
    checkOutput("tx_req_left_over", exp_tx.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 Parameter: SLAVE_ADDR, 7'h50, 7-bit bus address this block responds to.
REQ-002 Parameter: FILT_LEN, 3, consecutive equal samples required by the glitch filter (REQ-030).
REQ-003 clk  input  1  system clock (40 MHz nominal; SCL at most 100 kHz).
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 scl  input  1  I2C clock from the master; asynchronous to clk.
REQ-006 sda  inout  1  I2C data; open-drain, driven only as 0 or high-Z, never 1.
REQ-007 tx_data  input  8  byte returned on a read; sampled when tx_req pulses.
REQ-008 tx_req  output  1  one-clk pulse when a read to SLAVE_ADDR is acknowledged.
REQ-009 rx_data  output  8  last byte received on a write.
REQ-010 rx_valid  output  1  one-clk pulse when rx_data is updated.
REQ-011 busy  output  1  high from an address match until STOP or restart.
REQ-012 ack_err  output  1  high after the master NACKs a read byte; cleared at the next START.

Function
REQ-013 scl and sda each pass through a 2-flop synchronizer; edges are detected on the synchronized values; pin-to-edge latency is 3 clk.
REQ-014 START = sda falling while scl high; STOP = sda rising while scl high; both are recognised in every state, including mid-byte.
REQ-015 States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
REQ-016 IDLE -> ADDR on START; any state -> ADDR on repeated START; any state -> IDLE on STOP.
REQ-017 ADDR: shift sda in MSB-first on each scl rising edge; after 8 bits compare [7:1] with SLAVE_ADDR; on match -> ADDR_ACK, else -> WAIT_STOP with sda released.
REQ-018 ACK drive: pull sda low from the scl falling edge after bit 8 to the scl falling edge after the 9th clock, then release (read: drive first data bit instead).
REQ-019 ADDR_ACK, R/W=0 -> WR_DATA; R/W=1 -> pulse tx_req, load tx_data into shift register, -> RD_DATA.
REQ-020 WR_DATA: shift 8 bits on scl rising; the clk after the 8th rising edge, rx_data <= byte and rx_valid pulses 1 clk; -> WR_ACK.
REQ-021 WR_ACK: ACK per REQ-018, then -> WR_DATA (multi-byte writes continue until STOP/restart).
REQ-022 RD_DATA: update sda on each scl falling edge, MSB-first (0 -> drive low, 1 -> high-Z); sda stable while scl high; after 8 bits release sda -> RD_ACK.
REQ-023 RD_ACK: sample sda on 9th scl rising; 0 (ACK) -> pulse tx_req, reload tx_data, -> RD_DATA; 1 (NACK) -> ack_err=1, -> WAIT_STOP.
REQ-024 WAIT_STOP: sda released, ignore scl until STOP or START.
REQ-025 busy=1 in ADDR_ACK through RD_ACK/WR_ACK after a match; 0 in IDLE, ADDR, WAIT_STOP.
REQ-026 Bit counter 0..7, wraps to 0 on every ACK phase and on START.

Reset
REQ-027 On rst: state=IDLE, sda released (high-Z) on the next clk, rx_data=8'h00, rx_valid=0, tx_req=0, busy=0, ack_err=0, bit counter=0, synchronizers=1.
REQ-028 rst mid-transfer aborts the transfer; no rx_valid/tx_req is generated for the partial byte; the block waits for a fresh START.

Configuration
REQ-029 Macro I2C_SLAVE_GLITCH_FILTER_EN selects an input filter.
REQ-030 Defined: each synchronized line changes only after FILT_LEN consecutive equal samples; pin-to-edge latency 3+FILT_LEN clk; pulses shorter than FILT_LEN clk are ignored.
REQ-031 Undefined: no filter; latency per REQ-013; all other behaviour identical.

Verification
REQ-032 Write 0x50/W, data 0xA5, 0x5A, STOP -> ACK on all 3 bytes; rx_valid pulses twice; rx_data 0xA5 then 0x5A; busy falls after STOP.
REQ-033 Write to 0x51 -> sda never driven low; no rx_valid; busy stays 0; state WAIT_STOP until STOP.
REQ-034 Read 0x50/R, tx_data=0x3C, master NACK -> tx_req once; master receives 0x3C; ack_err=1; IDLE after STOP.
REQ-035 Write 0x50/W, 4 data bits, repeated START, 0x50/R -> no rx_valid; ADDR ACKed; read proceeds normally.
REQ-036 rst asserted at data bit 5 -> sda high-Z next clk; all outputs at reset values; next START accepted.
REQ-037 2-clk sda low glitch while scl high -> with I2C_SLAVE_GLITCH_FILTER_EN no START is detected; without the macro, START is detected.
